// File: rtl/xgmm_writer.sv
// Moves words from the pattern and attribute FIFOs into video memory, one write
// at a time, alternating between sources when both have data waiting.
module xgmm_writer #(
    parameter int P_IDX_W = 4,
    parameter int A_IDX_W = 2
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        p_empty,
    input  logic        a_empty,
    input  logic [15:0] p_data,
    input  logic [15:0] a_data,
    input  logic [11:0] par,
    input  logic [12:0] aar,
    output logic        p_pop,
    output logic        a_pop,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_sel,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        POP,
        CAPT,
        WRITE
    } state_t;

    state_t              state, state_nxt;
    logic                pick_q, pick_nxt;   // 1 = attribute source
    logic                last_attr;
    logic [P_IDX_W-1:0]  p_idx;
    logic [A_IDX_W-1:0]  a_idx;
    logic                p_empty_q, a_empty_q;
    logic                p_clr, a_clr;
    logic [15:0]         p_addr, a_addr;

    assign p_clr  = p_empty & ~p_empty_q;
    assign a_clr  = a_empty & ~a_empty_q;
    assign p_addr = 16'({par, p_idx});
    assign a_addr = 16'({1'b0, aar, a_idx});
    assign busy   = (state != IDLE);

    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        pick_nxt  = pick_q;
        p_pop     = 1'b0;
        a_pop     = 1'b0;
        mem_req   = 1'b0;
        case (state)
            IDLE: begin
                if (!p_empty || !a_empty) begin
                    state_nxt = POP;
                    pick_nxt  = (!p_empty && !a_empty) ? ~last_attr : p_empty;
                end
            end
            POP: begin
                p_pop     = ~pick_q & ~p_empty;
                a_pop     =  pick_q & ~a_empty;
                state_nxt = CAPT;
            end
            CAPT: begin
                state_nxt = WRITE;
            end
            WRITE: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state     <= IDLE;
            pick_q    <= 1'b0;
            last_attr <= 1'b1;
            p_idx     <= '0;
            a_idx     <= '0;
            p_empty_q <= 1'b1;
            a_empty_q <= 1'b1;
            mem_sel   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_nxt;
            pick_q    <= pick_nxt;
            p_empty_q <= p_empty;
            a_empty_q <= a_empty;

            // Address is frozen here so later par/aar writes cannot disturb this word.
            if (state == POP) begin
                mem_sel  <= pick_q;
                mem_addr <= pick_q ? a_addr : p_addr;
            end
            if (state == CAPT) begin
                mem_wdata <= mem_sel ? a_data : p_data;
            end
            if (state == WRITE && mem_gnt) begin
                last_attr <= mem_sel;
            end

            // A FIFO draining restarts its index; that wins over a same-cycle pop.
            if (p_clr) begin
                p_idx <= '0;
            end else if (p_pop) begin
                p_idx <= p_idx + 1'b1;
            end
            if (a_clr) begin
                a_idx <= '0;
            end else if (a_pop) begin
                a_idx <= a_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_xgmm_writer.sv
// Bench for xgmm_writer: FIFO models feed the DUT, a per-source scoreboard predicts
// every completed write from the arbitration and indexing rules.
module tb_xgmm_writer;

    localparam int PW = 4;
    localparam int AW = 2;

    logic        clk_sys = 1'b0;
    logic        rst_n, p_empty, a_empty, mem_gnt;
    logic [15:0] p_data, a_data;
    logic [11:0] par;
    logic [12:0] aar;
    logic        p_pop, a_pop, mem_req, mem_sel, busy;
    logic [15:0] mem_addr, mem_wdata;

    always #5 clk_sys = ~clk_sys;

    xgmm_writer #(.P_IDX_W(PW), .A_IDX_W(AW)) dut (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .p_empty   (p_empty),
        .a_empty   (a_empty),
        .p_data    (p_data),
        .a_data    (a_data),
        .par       (par),
        .aar       (aar),
        .p_pop     (p_pop),
        .a_pop     (a_pop),
        .mem_req   (mem_req),
        .mem_gnt   (mem_gnt),
        .mem_sel   (mem_sel),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    logic [15:0] p_q[$], a_q[$];
    wr_t         exp_p[$], exp_a[$];
    logic        order_q[$];
    logic [15:0] p_addr_log[$], a_addr_log[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [PW-1:0] p_idx_m = '0;
    logic [AW-1:0] a_idx_m = '0;
    logic last_m = 1'b1, pend_m = 1'b0, exp_pick = 1'b0;
    logic pe_prev_m = 1'b1, ae_prev_m = 1'b1;
    logic pe_edge = 1'b1, ae_edge = 1'b1, rst_edge = 1'b0;

    // Monitor state
    logic        busy_prev = 1'b0, wait_prev = 1'b0, gnt_prev = 1'b0, sel_prev = 1'b0;
    logic [15:0] addr_prev = '0, wdata_prev = '0, last_p_data = '0;
    int          busy_cnt = 0, pop_cnt = 0, wr_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #2;
    endtask

    task automatic push_p(input logic [15:0] w);
        p_q.push_back(w);
        p_empty = 1'b0;
    endtask

    task automatic push_a(input logic [15:0] w);
        a_q.push_back(w);
        a_empty = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        logic done;
        done = 1'b0;
        for (int n = 0; n < budget; n++) begin
            tick();
            if (!busy && p_q.size() == 0 && a_q.size() == 0 &&
                exp_p.size() == 0 && exp_a.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check("drain", done, 1);
    endtask

    task automatic wait_req(input int budget);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < budget; n++) begin
            tick();
            if (mem_req) begin
                seen = 1'b1;
                break;
            end
        end
        check("req_seen", seen, 1);
    endtask

    // Model: what the DUT sampled at each edge, reset, and index clearing on a drain.
    always @(posedge clk_sys) begin
        rst_edge = rst_n;
        pe_edge  = p_empty;
        ae_edge  = a_empty;
        if (!rst_n) begin
            exp_p.delete();
            exp_a.delete();
            p_idx_m   = '0;
            a_idx_m   = '0;
            last_m    = 1'b1;
            pe_prev_m = 1'b1;
            ae_prev_m = 1'b1;
        end else begin
            if (p_empty && !pe_prev_m) p_idx_m = '0;
            if (a_empty && !ae_prev_m) a_idx_m = '0;
            pe_prev_m = p_empty;
            ae_prev_m = a_empty;
        end
    end

    // Monitor, scoreboard and FIFO models, all evaluated mid-cycle.
    always @(negedge clk_sys) begin
        logic [15:0] w;
        wr_t         e;
        if (rst_edge) begin
            if (wait_prev) begin
                check("req_hold", mem_req, 1);
                check("addr_hold", mem_addr, addr_prev);
                check("wdata_hold", mem_wdata, wdata_prev);
                check("sel_hold", mem_sel, sel_prev);
            end
            if (gnt_prev) check("req_low_after_gnt", mem_req, 0);
            if (busy && !busy_prev) begin
                exp_pick = (!pe_edge && !ae_edge) ? ~last_m : pe_edge;
                check("arb_pick", {a_pop, p_pop}, exp_pick ? 2'b10 : 2'b01);
                pend_m = exp_pick;
            end else if (p_pop || a_pop) begin
                check("stray_pop", {a_pop, p_pop}, 2'b00);
            end
            if (p_pop) check("p_pop_gate", p_empty, 0);
            if (a_pop) check("a_pop_gate", a_empty, 0);
            if (mem_req && mem_gnt) begin
                wr_cnt++;
                order_q.push_back(mem_sel);
                check("wr_sel", mem_sel, pend_m);
                if (mem_sel) begin
                    check("a_pending", exp_a.size() != 0, 1);
                    if (exp_a.size() != 0) begin
                        e = exp_a.pop_front();
                        check("a_addr", mem_addr, e.addr);
                        check("a_data", mem_wdata, e.data);
                    end
                    a_addr_log.push_back(mem_addr);
                end else begin
                    check("p_pending", exp_p.size() != 0, 1);
                    if (exp_p.size() != 0) begin
                        e = exp_p.pop_front();
                        check("p_addr", mem_addr, e.addr);
                        check("p_data", mem_wdata, e.data);
                    end
                    p_addr_log.push_back(mem_addr);
                    last_p_data = mem_wdata;
                end
                last_m = pend_m;
            end
            if (busy) busy_cnt++;
            if (p_pop || a_pop) pop_cnt++;
        end
        busy_prev  = busy;
        wait_prev  = mem_req && !mem_gnt;
        gnt_prev   = mem_req && mem_gnt;
        addr_prev  = mem_addr;
        wdata_prev = mem_wdata;
        sel_prev   = mem_sel;

        if (p_pop && p_q.size() != 0) begin
            w = p_q.pop_front();
            p_data = w;
            e.addr = 16'({par, p_idx_m});
            e.data = w;
            exp_p.push_back(e);
            p_idx_m++;
        end
        if (a_pop && a_q.size() != 0) begin
            w = a_q.pop_front();
            a_data = w;
            e.addr = 16'({1'b0, aar, a_idx_m});
            e.data = w;
            exp_a.push_back(e);
            a_idx_m++;
        end
        p_empty = (p_q.size() == 0);
        a_empty = (a_q.size() == 0);
    end

    initial begin
        logic [15:0] e_addr;
        rst_n   = 1'b0;
        p_empty = 1'b1;
        a_empty = 1'b1;
        mem_gnt = 1'b0;
        p_data  = '0;
        a_data  = '0;
        par     = '0;
        aar     = '0;
        repeat (3) tick();
        @(negedge clk_sys);
        check("rst_p_pop", p_pop, 0);
        check("rst_a_pop", a_pop, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_sel", mem_sel, 0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_mem_wdata", mem_wdata, 16'h0000);
        check("rst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single pattern word with grant tied high
        par = 12'h012;
        mem_gnt = 1'b1;
        busy_cnt = 0;
        pop_cnt = 0;
        p_addr_log.delete();
        push_p(16'hBEEF);
        wait_done(20);
        check("single_busy_cycles", busy_cnt, 3);
        check("single_pops", pop_cnt, 1);
        check("single_addr", p_addr_log.size() != 0 ? p_addr_log[0] : 16'hxxxx, 16'h0120);
        check("single_data", last_p_data, 16'hBEEF);

        // Burst of 16 pattern words, then one more after the drain
        par = 12'h001;
        wr_cnt = 0;
        p_addr_log.delete();
        for (int i = 0; i < 16; i++) push_p(16'($urandom));
        wait_done(200);
        check("burst_count", wr_cnt, 16);
        for (int i = 0; i < 16 && i < p_addr_log.size(); i++)
            check("burst_addr", p_addr_log[i], 16'h0010 + 16'(i));
        push_p(16'h1234);
        wait_done(20);
        check("after_drain_addr", p_addr_log.size() == 17 ? p_addr_log[16] : 16'hxxxx, 16'h0010);

        // Index wrap without a drain
        p_addr_log.delete();
        for (int i = 0; i < 16; i++) push_p(16'($urandom));
        for (int n = 0; n < 200 && p_q.size() > 12; n++) tick();
        for (int i = 0; i < 4; i++) push_p(16'($urandom));
        wait_done(200);
        check("wrap_addr", p_addr_log.size() == 20 ? p_addr_log[16] : 16'hxxxx, 16'h0010);

        // Round-robin from reset with both sources loaded
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        aar = 13'h0003;
        par = 12'h040;
        order_q.delete();
        a_addr_log.delete();
        push_p(16'hA001);
        push_p(16'hA002);
        push_a(16'hB001);
        push_a(16'hB002);
        wait_done(40);
        check("rr_len", order_q.size(), 4);
        for (int i = 0; i < 4 && i < order_q.size(); i++)
            check("rr_order", order_q[i], (i % 2 == 1) ? 1 : 0);
        check("rr_a_addr0", a_addr_log.size() > 0 ? a_addr_log[0] : 16'hxxxx, 16'h000C);
        check("rr_a_addr1", a_addr_log.size() > 1 ? a_addr_log[1] : 16'hxxxx, 16'h000D);

        // Grant withheld for 10 cycles
        mem_gnt = 1'b0;
        wr_cnt = 0;
        push_p(16'hCAFE);
        wait_req(10);
        pop_cnt = 0;
        repeat (10) tick();
        check("stall_req", mem_req, 1);
        check("stall_pops", pop_cnt, 0);
        check("stall_no_write", wr_cnt, 0);
        mem_gnt = 1'b1;
        tick();
        check("stall_complete", wr_cnt, 1);
        check("stall_idle", busy, 0);
        wait_done(10);

        // Reset while waiting for grant, then indices must restart at 0
        mem_gnt = 1'b0;
        push_p(16'hDEAD);
        wait_req(10);
        push_a(16'h7777);
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        check("rst_wr_req", mem_req, 0);
        check("rst_wr_busy", busy, 0);
        rst_n = 1'b1;
        mem_gnt = 1'b1;
        p_addr_log.delete();
        a_addr_log.delete();
        push_p(16'h0F0F);
        wait_done(40);
        e_addr = {par, 4'h0};
        check("rst_p_idx", p_addr_log.size() != 0 ? p_addr_log[0] : 16'hxxxx, e_addr);
        e_addr = {1'b0, aar, 2'b00};
        check("rst_a_idx", a_addr_log.size() != 0 ? a_addr_log[0] : 16'hxxxx, e_addr);

        // Three attribute words, drain, then one more restarts at index 0
        aar = 13'h01A5;
        a_addr_log.delete();
        for (int i = 0; i < 3; i++) push_a(16'($urandom));
        wait_done(40);
        push_a(16'h4444);
        wait_done(20);
        e_addr = {1'b0, aar, 2'b00};
        check("a_clear_addr", a_addr_log.size() == 4 ? a_addr_log[3] : 16'hxxxx, e_addr);

        // Randomized traffic, grant and base-address changes
        for (int n = 0; n < 1500; n++) begin
            tick();
            mem_gnt = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0 && p_q.size() < 16) push_p(16'($urandom));
            if ($urandom_range(0, 3) == 0 && a_q.size() < 4) push_a(16'($urandom));
            if ($urandom_range(0, 15) == 0) par = 12'($urandom);
            if ($urandom_range(0, 15) == 0) aar = 13'($urandom);
        end
        mem_gnt = 1'b1;
        wait_done(400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/xgmm_writer.md
XGMM_WRITER -- requirements
Module: xgmm_writer

Interface
REQ-001 Parameter P_IDX_W, default 4: pattern word-index width; pattern FIFO depth is 2^P_IDX_W.
REQ-002 Parameter A_IDX_W, default 2: attribute word-index width; attribute FIFO depth is 2^A_IDX_W.
REQ-003 clk_sys  in  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset, sampled on rising clk_sys.
REQ-005 p_empty  in  1  pattern FIFO empty.
REQ-006 a_empty  in  1  attribute FIFO empty.
REQ-007 p_data  in  16  pattern FIFO head word; valid the cycle after p_pop.
REQ-008 a_data  in  16  attribute FIFO head word; valid the cycle after a_pop.
REQ-009 par  in  12  pattern base address from the CPU register interface.
REQ-010 aar  in  13  attribute base address from the CPU register interface.
REQ-011 p_pop  out  1  one-cycle pop strobe to the pattern FIFO.
REQ-012 a_pop  out  1  one-cycle pop strobe to the attribute FIFO.
REQ-013 mem_req  out  1  video-memory write request.
REQ-014 mem_gnt  in  1  video-memory grant; a write completes in the cycle mem_req and mem_gnt are both high.
REQ-015 mem_sel  out  1  0 = pattern memory, 1 = attribute memory.
REQ-016 mem_addr  out  16  word address: {par, p_idx} for pattern; {1'b0, aar, a_idx} for attribute.
REQ-017 mem_wdata  out  16  write data.
REQ-018 busy  out  1  high in every state other than IDLE.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, POP, CAPT, WRITE.
REQ-020 IDLE: if either FIFO is non-empty, the FSM SHALL select a source and go to POP; otherwise it stays in IDLE.
REQ-021 Selection SHALL be round-robin: when both sources are non-empty, the source not served last wins; a single non-empty source always wins; last_served resets to attribute, so pattern wins first.
REQ-022 POP: the FSM SHALL assert the selected pop for exactly one cycle, latch mem_sel, and latch the address from the current par/aar and index; the selected index SHALL then increment modulo its width. The next state is CAPT.
REQ-023 CAPT: the FSM SHALL register p_data or a_data into mem_wdata; the next state is WRITE.
REQ-024 WRITE: mem_req SHALL be high; mem_addr, mem_wdata and mem_sel SHALL hold stable until mem_gnt; on mem_gnt the FSM SHALL update last_served and go to IDLE with mem_req low in that following cycle.
REQ-025 Minimum service time SHALL be 4 cycles per word (POP, CAPT, WRITE with immediate grant, IDLE); mem_gnt may be withheld indefinitely without data loss.
REQ-026 The pop outputs SHALL be asserted only in POP, and never when the corresponding empty input is high.
REQ-027 Index clear: on a rising edge of p_empty (registered previous value was 0, current value is 1), p_idx SHALL clear to 0; a_idx SHALL clear the same way on a_empty. Clear SHALL take priority over an increment in the same cycle.
REQ-028 Index wrap: p_idx SHALL wrap from 2^P_IDX_W-1 to 0, and a_idx from 2^A_IDX_W-1 to 0, with no other side effect.
REQ-029 The address SHALL be latched only in POP; a later change to par or aar SHALL NOT alter an in-flight write.
REQ-030 mem_req SHALL NOT deassert in WRITE before mem_gnt is sampled high.

Reset
REQ-031 On rst_n=0 at a clock edge, the following SHALL hold on the next cycle: state=IDLE; p_pop=0; a_pop=0; mem_req=0; mem_sel=0; mem_addr=0; mem_wdata=0; busy=0; p_idx=0; a_idx=0; last_served=attribute; both previous-empty registers=1.
REQ-032 Reset asserted mid-operation, including WRITE awaiting grant, SHALL abandon the write with no further pop or req; a word already popped is discarded.

Verification
REQ-033 Single pattern word: par=12'h012, p_data=16'hBEEF, p_empty falls, mem_gnt tied high -> p_pop pulses once; mem_req=1 with mem_addr=16'h0120, mem_sel=0, mem_wdata=16'hBEEF; busy for 3 cycles.
REQ-034 Burst of 16 pattern words, par=12'h001 -> addresses 16'h0010 through 16'h001F in order; p_idx wraps to 0; a rising edge of p_empty leaves p_idx=0.
REQ-035 Both FIFOs each holding 2 words, aar=13'h0003 -> grant order P, A, P, A; attribute addresses 16'h000C then 16'h000D, with mem_sel=1.
REQ-036 mem_gnt held low for 10 cycles in WRITE -> mem_req, mem_addr and mem_wdata stay constant; no pop occurs; the write completes on the cycle mem_gnt rises.
REQ-037 rst_n pulled low while in WRITE awaiting grant -> the next cycle shows mem_req=0, busy=0, and all indices 0.
REQ-038 3 attribute words, then a_empty rises, then 1 more word -> the 4th word goes to a_idx=0, i.e. address {aar,2'b00}.
